// File: rtl/result_block_writer.sv
// result_block_writer
// Collects 32-bit measurement records into a 512-byte buffer (one SD block)
// and streams the block byte by byte, big-endian, to an sdspihost-style
// block writer. A block is written when 128 words have been accepted or when
// flush is pulsed with a partially filled buffer; unwritten words go out as
// zero bytes. An SD error parks the block in ERROR until start_log or rst.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   base_addr, start_log      first block address / restart of a logging run
//   rec_valid, rec_data,
//   rec_ready                 record handshake (accepted only while filling)
//   flush                     write out the partially filled buffer
//   spi_busy, spi_err         status from sdspihost
//   spi_w_block, spi_w_byte,
//   spi_data_in,
//   spi_block_addr            block-write controls to sdspihost
//   blocks_written, err, busy run status
module result_block_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] base_addr,
    input  logic        start_log,
    input  logic        rec_valid,
    input  logic [31:0] rec_data,
    output logic        rec_ready,
    input  logic        flush,
    input  logic        spi_busy,
    input  logic        spi_err,
    output logic        spi_w_block,
    output logic        spi_w_byte,
    output logic [7:0]  spi_data_in,
    output logic [31:0] spi_block_addr,
    output logic [31:0] blocks_written,
    output logic        err,
    output logic        busy
);

    typedef enum logic [2:0] {
        FILL, WAIT_IDLE, ISSUE, WAIT_REQ, SEND, WAIT_DONE, ERROR
    } state_t;

    state_t       state_q;
    logic [6:0]   widx_q;        // next word to fill
    logic [9:0]   byte_cnt_q;    // bytes sent; bit 9 set means all 512 sent
    logic [127:0] mark_q;        // words written since the last block
    logic [31:0]  mem [128];
    logic [31:0]  rd_word_q;
    logic         rd_mark_q;
    logic         spi_w_block_q;
    logic         spi_w_byte_q;
    logic [7:0]   spi_data_q;
    logic [31:0]  addr_q;
    logic [31:0]  blocks_q;
    logic         err_q;

    logic         accept;
    logic [9:0]   cnt_next;
    logic [6:0]   rd_idx;
    logic [7:0]   cur_byte;

    assign accept = rec_valid && (state_q == FILL);

    // The counter advances on the spi_w_byte cycle; the RAM is addressed with
    // the advanced value so the next word is already read out by the time
    // WAIT_REQ needs it.
    assign cnt_next = (state_q == SEND && spi_w_byte_q) ? byte_cnt_q + 10'd1 : byte_cnt_q;
    assign rd_idx   = cnt_next[8:2];

    // Buffer RAM: one write port from the record side, registered read.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[widx_q] <= rec_data;
        end
        rd_word_q <= mem[rd_idx];
    end

    // Big-endian lane select; unmarked words are sent as zero padding.
    always_comb begin
        cur_byte = 8'h00;
        if (rd_mark_q) begin
            case (byte_cnt_q[1:0])
                2'd0:    cur_byte = rd_word_q[31:24];
                2'd1:    cur_byte = rd_word_q[23:16];
                2'd2:    cur_byte = rd_word_q[15:8];
                default: cur_byte = rd_word_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        rd_mark_q <= mark_q[rd_idx];
        if (rst) begin
            state_q       <= FILL;
            widx_q        <= 7'd0;
            byte_cnt_q    <= 10'd0;
            mark_q        <= '0;
            spi_w_block_q <= 1'b0;
            spi_w_byte_q  <= 1'b0;
            spi_data_q    <= 8'h00;
            addr_q        <= base_addr;
            blocks_q      <= 32'd0;
            err_q         <= 1'b0;
        end else if (spi_err && state_q != FILL && state_q != ERROR) begin
            state_q       <= ERROR;
            spi_w_block_q <= 1'b0;
            spi_w_byte_q  <= 1'b0;
            err_q         <= 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        mark_q[widx_q] <= 1'b1;
                        widx_q         <= widx_q + 7'd1;
                        // A flush together with a word includes that word.
                        if (widx_q == 7'd127 || flush) begin
                            state_q <= WAIT_IDLE;
                        end
                    end else if (flush && widx_q != 7'd0) begin
                        state_q <= WAIT_IDLE;
                    end
                    if (start_log && widx_q == 7'd0) begin
                        addr_q   <= base_addr;
                        blocks_q <= 32'd0;
                        err_q    <= 1'b0;
                    end
                end
                WAIT_IDLE: begin
                    if (!spi_busy) begin
                        state_q       <= ISSUE;
                        spi_w_block_q <= 1'b1;
                        byte_cnt_q    <= 10'd0;
                    end
                end
                ISSUE: begin
                    if (spi_busy) begin
                        state_q <= WAIT_REQ;
                    end
                end
                WAIT_REQ: begin
                    if (!spi_busy && !byte_cnt_q[9]) begin
                        spi_data_q   <= cur_byte;
                        spi_w_byte_q <= 1'b1;
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    if (spi_w_byte_q) begin
                        spi_w_byte_q <= 1'b0;
                        byte_cnt_q   <= cnt_next;
                    end
                    if (spi_busy) begin
                        state_q <= cnt_next[9] ? WAIT_DONE : WAIT_REQ;
                    end
                end
                WAIT_DONE: begin
                    if (!spi_busy) begin
                        spi_w_block_q <= 1'b0;
                        blocks_q      <= blocks_q + 32'd1;
                        addr_q        <= addr_q + 32'd1;
                        widx_q        <= 7'd0;
                        mark_q        <= '0;
                        byte_cnt_q    <= 10'd0;
                        state_q       <= FILL;
                    end
                end
                ERROR: begin
                    if (start_log) begin
                        state_q    <= FILL;
                        addr_q     <= base_addr;
                        blocks_q   <= 32'd0;
                        err_q      <= 1'b0;
                        widx_q     <= 7'd0;
                        mark_q     <= '0;
                        byte_cnt_q <= 10'd0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign rec_ready      = (state_q == FILL);
    assign busy           = (state_q != FILL);
    assign spi_w_block    = spi_w_block_q;
    assign spi_w_byte     = spi_w_byte_q;
    assign spi_data_in    = spi_data_q;
    assign spi_block_addr = addr_q;
    assign blocks_written = blocks_q;
    assign err            = err_q;

endmodule
